// File: rtl/alu_multicycle_pkg.sv
// Shared opcode encodings, FSM state type and mul/div mode select for the multicycle ALU.
package alu_multicycle_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpSltu = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;
  localparam logic [3:0] OpDivu = 4'd12;

  localparam logic ModeMul = 1'b0;
  localparam logic ModeDiv = 1'b1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

endpackage

// File: rtl/alu_iterative_muldiv.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider sharing one
// accumulator and shift register. hi/lo present the value after the current step.
module alu_iterative_muldiv
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             finished
);

  logic [WIDTH-1:0] acc_q, acc_d, shr_q, shr_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d, run_q, run_d;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q, shr_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (mode_q == ModeDiv) begin
      // Restoring step: keep the subtraction only when it did not borrow.
      if (!diff[WIDTH]) begin
        hi = diff[WIDTH-1:0];
        lo = {shr_q[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {shr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], shr_q[WIDTH-1:1]};
    end
    finished = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    acc_d  = acc_q;
    shr_d  = shr_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    run_d  = run_q;
    if (go) begin
      acc_d  = '0;
      shr_d  = a;
      b_d    = b;
      cnt_d  = '0;
      mode_d = mode;
      run_d  = 1'b1;
    end else if (run_q) begin
      acc_d = hi;
      shr_d = lo;
      cnt_d = cnt_q + 1'b1;
      if (finished) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      shr_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      mode_q <= ModeMul;
      run_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      shr_q  <= shr_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: registered single-cycle ops plus iterative MUL/DIVU, start/busy/done handshake.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       selector,
  input  logic [WIDTH-1:0] input_data_A,
  input  logic [WIDTH-1:0] input_data_B,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zeroFlag,
  output logic             overflowFlag,
  output logic             divZeroFlag,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ShW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;

  logic [WIDTH-1:0] add_res, sub_res, sc_lo, sc_hi, md_hi, md_lo;
  logic [ShW-1:0]   shamt;
  logic             sc_ovf, sc_dz, b_zero, iterative, go, md_finished;

  assign add_res   = input_data_A + input_data_B;
  assign sub_res   = input_data_A - input_data_B;
  assign shamt     = input_data_B[ShW-1:0];
  assign b_zero    = (input_data_B == '0);
  assign iterative = (selector == OpMul) || ((selector == OpDivu) && !b_zero);

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    case (selector)
      OpAdd: begin
        sc_lo  = add_res;
        sc_ovf = (input_data_A[WIDTH-1] == input_data_B[WIDTH-1]) &&
                 (add_res[WIDTH-1] != input_data_A[WIDTH-1]);
      end
      OpSub: begin
        sc_lo  = sub_res;
        sc_ovf = (input_data_A[WIDTH-1] != input_data_B[WIDTH-1]) &&
                 (sub_res[WIDTH-1] != input_data_A[WIDTH-1]);
      end
      OpAnd:  sc_lo = input_data_A & input_data_B;
      OpOr:   sc_lo = input_data_A | input_data_B;
      OpXor:  sc_lo = input_data_A ^ input_data_B;
      OpNor:  sc_lo = ~(input_data_A | input_data_B);
      OpSlt:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(input_data_A) < $signed(input_data_B)};
      OpSltu: sc_lo = {{(WIDTH-1){1'b0}}, input_data_A < input_data_B};
      OpSll:  sc_lo = input_data_A << shamt;
      OpSrl:  sc_lo = input_data_A >> shamt;
      OpSra:  sc_lo = $signed(input_data_A) >>> shamt;
      OpDivu: begin
        // Only reached here when B is zero; nonzero divisors go to the iterative unit.
        sc_lo = '1;
        sc_hi = input_data_A;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    go      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (iterative) begin
            go      = 1'b1;
            state_d = StIter;
          end else begin
            state_d = StDone;
            lo_d    = sc_lo;
            hi_d    = sc_hi;
            zero_d  = (sc_lo == '0);
            ovf_d   = sc_ovf;
            dz_d    = sc_dz;
          end
        end
      end
      StIter: begin
        if (md_finished) begin
          state_d = StDone;
          lo_d    = md_lo;
          hi_d    = md_hi;
          zero_d  = (md_lo == '0);
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  alu_iterative_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .mode     ((selector == OpDivu) ? ModeDiv : ModeMul),
    .a        (input_data_A),
    .b        (input_data_B),
    .hi       (md_hi),
    .lo       (md_lo),
    .finished (md_finished)
  );

  assign result_lo    = lo_q;
  assign result_hi    = hi_q;
  assign zeroFlag     = zero_q;
  assign overflowFlag = ovf_q;
  assign divZeroFlag  = dz_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule
